// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Brief    : IDLE/DECODE/EXEC/MEM/WB instruction sequencer with fetch and
//            data-memory handshakes and a stalled-access timeout.
//            Define PERF_COUNTER_EN to build the saturating retire counter.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
  parameter int                  OPCODE_W    = 3,
  parameter logic [OPCODE_W-1:0] LOAD_OP     = OPCODE_W'(3'b000),
  parameter logic [OPCODE_W-1:0] STORE_OP    = OPCODE_W'(3'b100),
  parameter int                  MEM_TIMEOUT = 16,
  parameter int                  CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] OpCode,
  input  logic                mem_ready,
  output logic                instr_ready,
  output logic                IRWriteEnable,
  output logic                PCWriteEnable,
  output logic                MemReadEnable,
  output logic                MemWriteEnable,
  output logic                RegWriteEnable,
  output logic                ResultSrc,
  output logic                mem_error,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    retired_count
);

  // wait counter only has to reach MEM_TIMEOUT-1
  localparam int c_WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t                r_state;
  logic [OPCODE_W-1:0]   r_opcodeQ;
  logic [c_WAIT_W-1:0]   r_waitCnt;
  logic                  r_memError;

  logic w_isLoad;
  logic w_isStore;
  logic w_inMem;
  logic w_inWb;
  logic w_accept;
  logic w_storeDone;
  logic w_timeout;

  assign w_isLoad    = (r_opcodeQ == LOAD_OP);
  assign w_isStore   = (r_opcodeQ == STORE_OP);
  assign w_inMem     = (r_state == S_MEM);
  assign w_inWb      = (r_state == S_WB);
  assign w_accept    = (r_state == S_IDLE) && instr_valid;
  assign w_storeDone = w_inMem && w_isStore && mem_ready;

  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout
      // a completing access in the last allowed cycle is not a timeout
      assign w_timeout = w_inMem && !mem_ready &&
                         (r_waitCnt == c_WAIT_W'(MEM_TIMEOUT - 1));
    end else begin : g_noTimeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_opcodeQ  <= '0;
      r_waitCnt  <= '0;
      r_memError <= 1'b0;
    end else begin
      r_memError <= w_timeout;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_opcodeQ <= OpCode;
            r_state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_waitCnt <= '0;
          r_state   <= (w_isLoad || w_isStore) ? S_MEM : S_EXEC;
        end
        S_EXEC: begin
          r_state <= S_WB;
        end
        S_MEM: begin
          if (mem_ready) begin
            r_state <= w_isLoad ? S_WB : S_IDLE;
          end else if (w_timeout) begin
            r_state <= S_IDLE;
          end else begin
            r_waitCnt <= r_waitCnt + c_WAIT_W'(1);
          end
        end
        S_WB: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready    = (r_state == S_IDLE);
  assign IRWriteEnable  = w_accept;
  assign MemReadEnable  = w_inMem && w_isLoad;
  assign MemWriteEnable = w_inMem && w_isStore;
  assign RegWriteEnable = w_inWb;
  assign PCWriteEnable  = w_inWb || w_storeDone;
  assign ResultSrc      = !(w_inWb && w_isLoad);
  assign mem_error      = r_memError;
  assign state          = r_state;

`ifdef PERF_COUNTER_EN
  logic [CNT_W-1:0] r_retiredCount;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retiredCount <= '0;
    end else if (PCWriteEnable && (r_retiredCount != {CNT_W{1'b1}})) begin
      r_retiredCount <= r_retiredCount + CNT_W'(1);
    end
  end

  assign retired_count = r_retiredCount;
`else
  assign retired_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// Bench for multicycle_control_unit: vector table driven into a scoreboard,
// plus hand-written reset and counter-saturation sequences.
module tb_multicycle_control_unit;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             instr_valid = 1'b0;
  logic [2:0]       OpCode = 3'd0;
  logic             mem_ready = 1'b0;
  logic             instr_ready;
  logic             IRWriteEnable;
  logic             PCWriteEnable;
  logic             MemReadEnable;
  logic             MemWriteEnable;
  logic             RegWriteEnable;
  logic             ResultSrc;
  logic             mem_error;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int expCount = 0;

  multicycle_control_unit #(
    .OPCODE_W   (3),
    .LOAD_OP    (3'b000),
    .STORE_OP   (3'b100),
    .MEM_TIMEOUT(16),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .OpCode        (OpCode),
    .mem_ready     (mem_ready),
    .instr_ready   (instr_ready),
    .IRWriteEnable (IRWriteEnable),
    .PCWriteEnable (PCWriteEnable),
    .MemReadEnable (MemReadEnable),
    .MemWriteEnable(MemWriteEnable),
    .RegWriteEnable(RegWriteEnable),
    .ResultSrc     (ResultSrc),
    .mem_error     (mem_error),
    .state         (state),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // stalls < 0 means mem_ready never rises; expRetire is the event cycle
  // (PC write or mem_error pulse) counted from the acceptance cycle
  typedef struct {
    logic [2:0] op;
    int         stalls;
    int         expRetire;
    logic       expReg;
    logic       expRes;
    logic       expErr;
    int         expRd;
    int         expWr;
    logic [2:0] expSt;
  } vec_t;

  typedef struct {
    int         cyc;
    logic       reg_;
    logic       res;
    logic       err;
    int         rd;
    int         wr;
    logic [2:0] st;
  } exp_t;

  exp_t sb[$];
  exp_t monE;
  vec_t vecs[12];
  vec_t aluVec;
  int   rdCnt = 0;
  int   wrCnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // event monitor: every PC write, register write or error pulse pops one record
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      rdCnt = 0;
      wrCnt = 0;
    end else begin
      if (MemReadEnable)  rdCnt = rdCnt + 1;
      if (MemWriteEnable) wrCnt = wrCnt + 1;
      if (PCWriteEnable || RegWriteEnable || mem_error) begin
        if (sb.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          monE = sb.pop_front();
          check("event_cycle", cyc, monE.cyc);
          check("pc_write", PCWriteEnable, !monE.err);
          check("reg_write", RegWriteEnable, monE.reg_);
          check("result_src", ResultSrc, monE.res);
          check("mem_error", mem_error, monE.err);
          check("mem_read_cycles", rdCnt, monE.rd);
          check("mem_write_cycles", wrCnt, monE.wr);
          check("event_state", state, monE.st);
          check("retired_count", retired_count, expCount);
`ifdef PERF_COUNTER_EN
          if (!monE.err && expCount != CNT_MAX) expCount = expCount + 1;
`endif
        end
        rdCnt = 0;
        wrCnt = 0;
      end
    end
  end

  task automatic runVec(input vec_t v);
    int t0;
    int budget;
    budget = 0;
    while (!instr_ready && budget < 40) begin
      @(posedge clk); #1;
      budget = budget + 1;
    end
    check("idle_before_issue", instr_ready, 1);
    OpCode = v.op;
    instr_valid = 1'b1;
    mem_ready = 1'b0;
    t0 = cyc;
    sb.push_back('{t0 + v.expRetire, v.expReg, v.expRes, v.expErr, v.expRd, v.expWr, v.expSt});
    #1;
    check("ir_write_T0", IRWriteEnable, 1);
    @(posedge clk); #1;
    for (int c = 1; c <= v.expRetire; c++) begin
      // junk on the fetch inputs while busy must be ignored
      if (c < v.expRetire) begin
        instr_valid = ($urandom_range(0, 1) == 1);
        OpCode = 3'($urandom_range(0, 7));
      end else begin
        instr_valid = 1'b0;
      end
      mem_ready = (v.stalls >= 0) && (c == 2 + v.stalls);
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          op      stalls retire reg   res   err   rd  wr  st
    vecs[0]  = '{3'b010, -1,  3,  1'b1, 1'b1, 1'b0, 0,  0,  3'd4};
    vecs[1]  = '{3'b111, -1,  3,  1'b1, 1'b1, 1'b0, 0,  0,  3'd4};
    vecs[2]  = '{3'b001, -1,  3,  1'b1, 1'b1, 1'b0, 0,  0,  3'd4};
    vecs[3]  = '{3'b000,  0,  3,  1'b1, 1'b0, 1'b0, 1,  0,  3'd4};
    vecs[4]  = '{3'b000,  3,  6,  1'b1, 1'b0, 1'b0, 4,  0,  3'd4};
    vecs[5]  = '{3'b100,  0,  2,  1'b0, 1'b1, 1'b0, 0,  1,  3'd3};
    vecs[6]  = '{3'b100,  2,  4,  1'b0, 1'b1, 1'b0, 0,  3,  3'd3};
    vecs[7]  = '{3'b100, -1, 18,  1'b0, 1'b1, 1'b1, 0,  16, 3'd0};
    vecs[8]  = '{3'b000, -1, 18,  1'b0, 1'b1, 1'b1, 16, 0,  3'd0};
    vecs[9]  = '{3'b100, 15, 17,  1'b0, 1'b1, 1'b0, 0,  16, 3'd3};
    vecs[10] = '{3'b000, 15, 18,  1'b1, 1'b0, 1'b0, 16, 0,  3'd4};
    vecs[11] = '{3'b011, -1,  3,  1'b1, 1'b1, 1'b0, 0,  0,  3'd4};
    aluVec   = '{3'b010, -1,  3,  1'b1, 1'b1, 1'b0, 0,  0,  3'd4};

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", state, 0);
    check("reset_instr_ready", instr_ready, 1);
    check("reset_result_src", ResultSrc, 1);
    check("reset_pc_write", PCWriteEnable, 0);
    check("reset_mem_error", mem_error, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) runVec(vecs[i]);

    // reset dropped in the middle of EXEC
    check("idle_before_reset_seq", instr_ready, 1);
    OpCode = 3'b010;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("seq_state_T1", state, 1);
    @(posedge clk); #1;
    check("seq_state_T2", state, 2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_state", state, 0);
    check("midrst_instr_ready", instr_ready, 1);
    check("midrst_enables", {IRWriteEnable, PCWriteEnable, MemReadEnable, MemWriteEnable, RegWriteEnable}, 0);
    check("midrst_mem_error", mem_error, 0);
    check("midrst_retired_count", retired_count, 0);
    expCount = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_state", state, 0);

    // 17 back-to-back retires drive the 4-bit counter into saturation
    for (int i = 0; i < 17; i++) runVec(aluVec);
    @(posedge clk); #1;
    check("final_retired_count", retired_count, expCount);
    check("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised multi-cycle successor to the single-cycle opcode decoder.
- Sequences each instruction through IDLE, DECODE, EXEC, MEM and WB states.
- Drives datapath enables: IR/PC write, register write, memory read/write, result mux select.
- Handshakes with the fetch stage (instr_valid/instr_ready) and data memory (mem_ready); aborts stalled memory accesses on timeout.

Parameters:
- OPCODE_W, 3, opcode width in bits.
- LOAD_OP, 3'b000, opcode value for LOAD; width OPCODE_W.
- STORE_OP, 3'b100, opcode value for STORE; width OPCODE_W.
- MEM_TIMEOUT, 16, max MEM-state cycles without mem_ready; 0 disables the timeout.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  fetched instruction available.
- OpCode  in  OPCODE_W  opcode of the offered instruction; sampled when instr_valid & instr_ready.
- mem_ready  in  1  data memory completes the access this cycle.
- instr_ready  out  1  controller accepts an instruction; equals state==IDLE.
- IRWriteEnable  out  1  latch instruction register; equals instr_valid & instr_ready.
- PCWriteEnable  out  1  advance PC; one-cycle pulse at retire.
- MemReadEnable  out  1  load access in progress.
- MemWriteEnable  out  1  store access in progress.
- RegWriteEnable  out  1  register file write.
- ResultSrc  out  1  0 = data memory, 1 = ALU.
- mem_error  out  1  registered one-cycle pulse on memory timeout.
- state  out  3  current state: IDLE=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- retired_count  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, opcode_q=0, wait_cnt=0, mem_error=0, retired_count=0.
  - instr_ready=1; all other enables 0; ResultSrc=1.
- Outputs other than mem_error and retired_count are combinational decodes of state, opcode_q, instr_valid and mem_ready.
- IDLE: on instr_valid, latch OpCode into opcode_q, assert IRWriteEnable, go to DECODE. Otherwise stay in IDLE.
- DECODE: one cycle. opcode_q equal to LOAD_OP or STORE_OP goes to MEM; any other opcode goes to EXEC.
- EXEC: one cycle, then WB.
- MEM:
  - MemReadEnable=1 for a load, MemWriteEnable=1 for a store; held every MEM cycle.
  - wait_cnt clears on MEM entry and increments on each MEM cycle with mem_ready=0.
  - mem_ready=1 with a load: go to WB.
  - mem_ready=1 with a store: PCWriteEnable=1 this cycle, go to IDLE. A store never writes the register file.
  - Timeout: if MEM_TIMEOUT>0, mem_ready=0 and wait_cnt==MEM_TIMEOUT-1, go to IDLE and pulse mem_error in the next cycle. No PC or register write, no retire count.
  - mem_ready=1 in the timeout cycle wins; the access completes normally.
- WB: RegWriteEnable=1, PCWriteEnable=1, ResultSrc = (opcode_q==LOAD_OP ? 0 : 1). Go to IDLE.
- ResultSrc=1 in every state except a load's WB.
- Latency from acceptance cycle T0:
  - ALU: WB at T3, instr_ready again at T4.
  - Load with immediate mem_ready: WB at T3.
  - Store with immediate mem_ready: retires at T2, IDLE at T3.
  - Each stalled MEM cycle adds 1.
- OpCode and instr_valid are ignored outside IDLE.
- Reset asserted mid-instruction forces IDLE immediately with no write pulses.
- Unknown opcodes are treated as ALU instructions.

Optional Feature:
- Macro PERF_COUNTER_EN.
- Defined: retired_count increments by 1 on each retire, i.e. cycles with PCWriteEnable=1 (WB, or store completion). Saturates at all-ones. Cleared only by reset.
- Undefined: no counter register; retired_count tied to 0. Port list identical in both builds.

Test Plan:
- Reset mid-EXEC: drop rst_n -> state=0 asynchronously, instr_ready=1, all enables 0, mem_error=0, retired_count=0.
- ALU op 3'b010 offered at T0 -> IRWriteEnable@T0, state 1@T1, 2@T2, 4@T3 with RegWriteEnable=1, PCWriteEnable=1, ResultSrc=1; instr_ready@T4.
- LOAD, mem_ready low 3 cycles then high:
  - MemReadEnable high for 4 cycles (T2..T5).
  - WB@T6 with ResultSrc=0, RegWriteEnable=1.
- STORE, mem_ready=1@T2 -> MemWriteEnable=1 and PCWriteEnable=1@T2; RegWriteEnable never asserted; IDLE@T3.
- STORE with mem_ready held 0, MEM_TIMEOUT=16:
  - MEM occupied T2..T17; IDLE@T18 with mem_error=1 for exactly one cycle.
  - No PC or register write. retired_count unchanged (PERF_COUNTER_EN build).
- PERF_COUNTER_EN with CNT_W=4: retire 17 ALU ops back-to-back -> retired_count reaches 15 and holds; undefined build reads 0 throughout.
